// File: rtl/seq_shift_pkg.sv
// Shared encodings for the sequential shifter: operation codes and FSM states.
package seq_shift_pkg;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shift_step.sv
// One-bit shift/rotate of the data register, selected by the latched operation.
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int L1 = 8
) (
  input  logic [L1-1:0] d,
  input  logic [1:0]    op,
  output logic [L1-1:0] q
);

  always_comb begin
    q = d;
    case (op)
      OP_SRL:  q = {1'b0, d[L1-1:1]};
      OP_SLL:  q = {d[L1-2:0], 1'b0};
      OP_SRA:  q = {d[L1-1], d[L1-1:1]};
      default: q = {d[0], d[L1-1:1]};
    endcase
  end

endmodule

// File: rtl/seq_shift.sv
// Multi-cycle shifter: one bit per clock, with valid/ready handshakes on both sides.
module seq_shift
  import seq_shift_pkg::*;
#(
  parameter int L1 = 8,
  parameter int L2 = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [L1-1:0] in1,
  input  logic [L2-1:0] in2,
  input  logic [1:0]    op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [L1-1:0] out,
  output logic          busy
);

  localparam int CW = $clog2(L1 + 1);
  // Wide enough to hold both the full shift amount and L1 itself without truncation.
  localparam int WW = ((L2 > CW) ? L2 : CW) + 1;

  state_t        state;
  logic [L1-1:0] data;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic [L1-1:0] step_q;
  logic [WW-1:0] in2_x;
  logic [CW-1:0] eff;

  // Clamp on the full amount first, then narrow into the counter.
  always_comb begin
    in2_x = WW'(in2);
    if (op == OP_ROR)
      eff = CW'(in2_x & WW'(L1 - 1));
    else if (in2_x >= WW'(L1))
      eff = CW'(L1);
    else
      eff = CW'(in2_x);
  end

  shift_step #(.L1(L1)) u_step (
    .d  (data),
    .op (op_q),
    .q  (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      data  <= '0;
      cnt   <= '0;
      op_q  <= OP_SRL;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data  <= in1;
            cnt   <= eff;
            op_q  <= op;
            state <= (eff == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          data <= step_q;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out       = data;

endmodule

// File: tb/tb_seq_shift.sv
// Directed and randomized checks of the sequential shifter at L1=8, L2=8.
module tb_seq_shift;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_shift #(.L1(8), .L2(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_shift(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] dbl;
    case (o)
      2'b00:   return a >> b;
      2'b01:   return a << b;
      2'b10:   return 8'($signed(a) >>> b);
      default: begin
        dbl = {a, a} >> (b % 8);
        return dbl[7:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [7:0] b);
    if (o == 2'b11) return int'(b % 8);
    return (b > 8) ? 8 : int'(b);
  endfunction

  // Runs one full transaction; hold_valid keeps in_valid high while waiting in DONE.
  task automatic do_op(input string name, input logic [1:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp, input int exp_lat,
                       input int gap, input logic hold_valid);
    int lat;
    @(negedge clk);
    chk({name, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; in1 = a; in2 = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = hold_valid;
    in1 = ~a; in2 = 8'd3; op = ~o;
    lat = 0;
    while (!out_valid && lat < 300) begin
      if (!busy) chk({name, " busy in shift"}, 32'(busy), 32'd1);
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " result"}, 32'(out), 32'(exp));
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      chk({name, " hold valid"}, 32'(out_valid), 32'd1);
      chk({name, " hold out"}, 32'(out), 32'(exp));
      chk({name, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk({name, " idle after hs"}, 32'({out_valid, busy, in_ready}), 32'b001);
    chk({name, " retained out"}, 32'(out), 32'(exp));
  endtask

  initial begin
    vecs[0]  = '{2'b00, 8'hB4, 8'd3,   8'h16, 3};
    vecs[1]  = '{2'b10, 8'h90, 8'd2,   8'hE4, 2};
    vecs[2]  = '{2'b01, 8'h81, 8'd1,   8'h02, 1};
    vecs[3]  = '{2'b11, 8'h01, 8'd9,   8'h80, 1};
    vecs[4]  = '{2'b00, 8'hA5, 8'd0,   8'hA5, 0};
    vecs[5]  = '{2'b00, 8'hFF, 8'd200, 8'h00, 8};
    vecs[6]  = '{2'b10, 8'h80, 8'd255, 8'hFF, 8};
    vecs[7]  = '{2'b11, 8'hC3, 8'd8,   8'hC3, 0};
    vecs[8]  = '{2'b01, 8'hFF, 8'd8,   8'h00, 8};
    vecs[9]  = '{2'b11, 8'h0F, 8'd4,   8'hF0, 4};
    vecs[10] = '{2'b10, 8'h7F, 8'd200, 8'h00, 8};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in1 = '0; in2 = '0; op = '0;
    #1;
    chk("reset state", 32'({out, out_valid, busy, in_ready}), 32'({8'h00, 3'b001}));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0, 1'b0);

    // Backpressure with in_valid held high in DONE.
    do_op("backpressure", 2'b00, 8'hB4, 8'd3, 8'h16, 3, 5, 1'b1);

    // Reset during the second SHIFT cycle of a 5-bit shift.
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; in1 = 8'hFF; in2 = 8'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre-reset busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("pre-reset shifting", 32'(out), 32'h7F);
    rst_n = 1'b0;
    #1;
    chk("mid-op reset", 32'({out, out_valid, busy, in_ready}), 32'({8'h00, 3'b001}));
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after reset", 2'b10, 8'h90, 8'd2, 8'hE4, 2, 1, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      logic [1:0] ro;
      logic [7:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      do_op($sformatf("rand%0d", n), ro, ra, rb, ref_shift(ro, ra, rb), ref_lat(ro, rb),
            $urandom_range(0, 3), 1'($urandom));
      if (ro == 2'b00) chk("rand srl vs >>", 32'(out), 32'(ra >> rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_shift.md
SEQ_SHIFT -- requirements
Module: seq_shift

Interface
REQ-001 The block SHALL have parameter L1, default 8, data width in bits; L1 is a power of two, at least 2.
REQ-002 The block SHALL have parameter L2, default 8, shift-amount width in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: the request is valid.
REQ-006 Port in_ready, output, 1 bit: the block can accept a request.
REQ-007 Port in1, input, L1 bits: operand to shift.
REQ-008 Port in2, input, L2 bits: shift amount, unsigned.
REQ-009 Port op, input, 2 bits: operation; 00 SRL, 01 SLL, 10 SRA, 11 ROR (rotate right).
REQ-010 Port out_valid, output, 1 bit: the result is valid.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 Port out, output, L1 bits: registered result.
REQ-013 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, SHIFT and DONE; in_ready SHALL equal (state==IDLE), with no combinational path from in_valid to in_ready.
REQ-015 Accept SHALL occur on an edge where in_valid && in_ready; in1, in2 and op are sampled only at accept and ignored otherwise.
REQ-016 At accept, the effective count eff SHALL be min(in2, L1) for SRL, SLL and SRA, and in2 mod L1 for ROR.
REQ-017 At accept, the data register SHALL load in1, the counter SHALL load eff, and op SHALL be latched; the next state SHALL be DONE if eff==0, else SHIFT.
REQ-018 In SHIFT, each edge SHALL shift the data register by exactly one bit as follows:
- SRL: zero fill from the MSB side.
- SLL: zero fill from the LSB side.
- SRA: MSB replicated.
- ROR: LSB moves to the MSB.
The counter SHALL decrement on the same edge; the edge on which the counter goes 1->0 SHALL move the state to DONE.
REQ-019 out_valid SHALL be high exactly when state==DONE; it SHALL rise after edge E0+eff, where E0 is the accept edge.
REQ-020 In DONE, out and out_valid SHALL hold stable until out_ready is high; on that edge the next state SHALL be IDLE.
REQ-021 Back-to-back operation SHALL NOT overlap: the next accept is possible no earlier than one edge after the result handshake, giving throughput of one op per eff+2 cycles.
REQ-022 out SHALL always reflect the data register, and SHALL retain the last result in IDLE until the next accept.
REQ-023 The SRL result SHALL equal in1 >> in2 for every in2, including in2 >= L1 (result 0).
REQ-024 The SRA result with in2 >= L1 SHALL be all copies of in1[L1-1].
REQ-025 in_valid asserted while in SHIFT or DONE SHALL have no effect.
REQ-026 The counter SHALL be $clog2(L1+1) bits wide; clamping SHALL be applied to the full L2-bit in2 before truncation.

Reset
REQ-027 While rst_n is low, the block SHALL be in state IDLE with out=0, out_valid=0, busy=0, in_ready=1, counter=0 and latched op=00.
REQ-028 Reset asserted mid-SHIFT or mid-DONE SHALL abort the operation immediately with no result delivered; after release the block SHALL accept on the first edge with in_valid.

Structure
REQ-029 Package seq_shift_pkg SHALL hold the op encodings (OP_SRL, OP_SLL, OP_SRA, OP_ROR) and the state enum.
REQ-030 A combinational sub-module shift_step (data, op -> data shifted by one bit) SHALL implement the per-edge shift; the FSM, counter and handshake SHALL stay in seq_shift.

Verification (L1=8, L2=8)
REQ-031 SRL scenario: in1=8'hB4, in2=3, op=00 -> out=8'h16; out_valid rises after E0+3, and busy is high for 3 cycles before it.
REQ-032 SRA, SLL and ROR scenarios:
- SRA: in1=8'h90, in2=2 -> 8'hE4.
- SLL: in1=8'h81, in2=1 -> 8'h02.
- ROR: in1=8'h01, in2=9 -> 8'h80, after 1 shift cycle.
REQ-033 Boundary amounts:
- in2=0 -> out=in1, with out_valid rising right after E0.
- SRL of 8'hFF with in2=200 -> 8'h00 after exactly 8 shift cycles.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> out, out_valid=1 and in_ready=0 stay stable, and no second accept occurs.
REQ-035 Reset mid-op: assert rst_n=0 at the second SHIFT cycle of an in2=5 op -> out=0, out_valid=0, in_ready=1 immediately; a new op after release completes correctly.
REQ-036 Random: 1000 random ops with random out_ready gaps, checked against a reference model; every SRL result matches the combinational slr output for the same in1/in2.
